// File: rtl/or_gate_if.sv
// Bundle of operand, qualifier and result signals for the or_gate primitive.
// master drives operands/controls; slave is the gate itself.
`timescale 1ns/1ps
interface or_gate_if #(
  parameter int WIDTH = 1
);
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             in_valid;
  logic             acc_clr;
  logic [WIDTH-1:0] out;
  logic [WIDTH-1:0] out_q;
  logic             out_valid;
  logic             any_q;
  logic [WIDTH-1:0] acc_q;

  modport master (
    output a, b, in_valid, acc_clr,
    input  out, out_q, out_valid, any_q, acc_q
  );

  modport slave (
    input  a, b, in_valid, acc_clr,
    output out, out_q, out_valid, any_q, acc_q
  );
endinterface

// File: rtl/or_gate.sv
// Bitwise 2-input OR with a combinational output, a registered valid-qualified copy,
// a reduction flag and an optional sticky accumulator enabled by OR_STICKY_EN.
`timescale 1ns/1ps
module or_gate #(
  parameter int WIDTH = 1
) (
  input  logic      clk,
  input  logic      rst,
  or_gate_if.slave  bus
);

  function automatic logic reduce_or(input logic [WIDTH-1:0] v);
    return |v;
  endfunction

  logic [WIDTH-1:0] or_p0;
  logic [WIDTH-1:0] data_d, data_q;
  logic             any_d, any_q;
  logic             vld_d, vld_q;

  assign or_p0   = bus.a | bus.b;
  assign bus.out = or_p0;

  always_comb begin
    data_d = data_q;
    any_d  = any_q;
    vld_d  = 1'b0;
    if (bus.in_valid) begin
      data_d = or_p0;
      any_d  = reduce_or(or_p0);
      vld_d  = 1'b1;
    end
  end

  // stage p0 -> p1: registered result, reduction flag and valid pulse
  always_ff @(posedge clk) begin
    if (rst) begin
      data_q <= '0;
      any_q  <= 1'b0;
      vld_q  <= 1'b0;
    end else begin
      data_q <= data_d;
      any_q  <= any_d;
      vld_q  <= vld_d;
    end
  end

  assign bus.out_q     = data_q;
  assign bus.any_q     = any_q;
  assign bus.out_valid = vld_q;

`ifdef OR_STICKY_EN
  logic [WIDTH-1:0] acc_d, acc_q;

  // A clear takes effect before the same-cycle accepted input is folded in.
  always_comb begin
    acc_d = acc_q;
    if (bus.acc_clr) begin
      acc_d = bus.in_valid ? or_p0 : '0;
    end else if (bus.in_valid) begin
      acc_d = acc_q | or_p0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      acc_q <= '0;
    end else begin
      acc_q <= acc_d;
    end
  end

  assign bus.acc_q = acc_q;
`else
  logic unused_acc_clr;
  assign unused_acc_clr = bus.acc_clr;
  assign bus.acc_q      = '0;
`endif

endmodule

// File: tb/tb_or_gate.sv
// Self-checking bench for or_gate: combinational truth table on a WIDTH=1 instance,
// then a vector table plus out_valid scoreboard on a WIDTH=8 instance.
`timescale 1ns/1ps
module tb_or_gate;

  logic clk;
  logic rst;
  logic clk_off;
  logic rst_off;

  or_gate_if #(.WIDTH(1)) bus1 ();
  or_gate_if #(.WIDTH(8)) bus8 ();

  or_gate #(.WIDTH(1)) dut1 (
    .clk (clk_off),
    .rst (rst_off),
    .bus (bus1.slave)
  );

  or_gate #(.WIDTH(8)) dut8 (
    .clk (clk),
    .rst (rst),
    .bus (bus8.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  task automatic check(input string name, input int idx, input logic [7:0] got, input logic [7:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s[%0d] got=%h expected=%h", name, idx, got, exp);
    end
  endtask

  typedef struct {
    logic       rst;
    logic       iv;
    logic       clr;
    logic [7:0] a;
    logic [7:0] b;
    logic [7:0] out_q;
    logic       vld;
    logic       any;
    logic [7:0] acc;
  } vec_t;

  vec_t vec [15];
  logic [7:0] sb_q [$];

  initial begin
    logic [7:0] exp_acc;
    logic [7:0] popped;

    // rst, iv, clr, a, b, out_q, vld, any, acc (sticky build)
    vec[0]  = '{1'b1, 1'b1, 1'b0, 8'h12, 8'h00, 8'h00, 1'b0, 1'b0, 8'h00};
    vec[1]  = '{1'b1, 1'b0, 1'b0, 8'h3C, 8'h01, 8'h00, 1'b0, 1'b0, 8'h00};
    vec[2]  = '{1'b0, 1'b1, 1'b0, 8'hA0, 8'h05, 8'hA5, 1'b1, 1'b1, 8'hA5};
    vec[3]  = '{1'b0, 1'b0, 1'b0, 8'h0F, 8'h00, 8'hA5, 1'b0, 1'b1, 8'hA5};
    vec[4]  = '{1'b0, 1'b1, 1'b0, 8'h00, 8'h00, 8'h00, 1'b1, 1'b0, 8'hA5};
    vec[5]  = '{1'b1, 1'b1, 1'b0, 8'hFF, 8'h00, 8'h00, 1'b0, 1'b0, 8'h00};
    vec[6]  = '{1'b0, 1'b1, 1'b0, 8'h01, 8'h00, 8'h01, 1'b1, 1'b1, 8'h01};
    vec[7]  = '{1'b0, 1'b1, 1'b0, 8'h00, 8'h10, 8'h10, 1'b1, 1'b1, 8'h11};
    vec[8]  = '{1'b0, 1'b1, 1'b0, 8'h80, 8'h80, 8'h80, 1'b1, 1'b1, 8'h91};
    vec[9]  = '{1'b0, 1'b0, 1'b0, 8'h7E, 8'h00, 8'h80, 1'b0, 1'b1, 8'h91};
    vec[10] = '{1'b0, 1'b1, 1'b1, 8'h04, 8'h00, 8'h04, 1'b1, 1'b1, 8'h04};
    vec[11] = '{1'b0, 1'b0, 1'b1, 8'h00, 8'h00, 8'h04, 1'b0, 1'b1, 8'h00};
    vec[12] = '{1'b0, 1'b1, 1'b0, 8'hFF, 8'h00, 8'hFF, 1'b1, 1'b1, 8'hFF};
    vec[13] = '{1'b1, 1'b0, 1'b1, 8'h00, 8'h00, 8'h00, 1'b0, 1'b0, 8'h00};
    vec[14] = '{1'b0, 1'b1, 1'b0, 8'h55, 8'hAA, 8'hFF, 1'b1, 1'b1, 8'hFF};

    // Combinational truth table on an unclocked WIDTH=1 instance
    clk_off       = 1'b0;
    rst_off       = 1'b0;
    bus1.in_valid = 1'b0;
    bus1.acc_clr  = 1'b0;
    for (int i = 0; i < 4; i++) begin
      logic [1:0] ab;
      ab     = 2'(i);
      bus1.a = ab[1];
      bus1.b = ab[0];
      #10;
      check("comb_w1", i, {7'd0, bus1.out}, (i == 0) ? 8'h00 : 8'h01);
    end

    bus8.a        = 8'h00;
    bus8.b        = 8'h00;
    bus8.in_valid = 1'b0;
    bus8.acc_clr  = 1'b0;
    rst           = 1'b1;

    for (int i = 0; i < 15; i++) begin
      @(negedge clk);
      rst           = vec[i].rst;
      bus8.in_valid = vec[i].iv;
      bus8.acc_clr  = vec[i].clr;
      bus8.a        = vec[i].a;
      bus8.b        = vec[i].b;
      if (vec[i].iv && !vec[i].rst) sb_q.push_back(vec[i].a | vec[i].b);
      #1;
      check("out", i, bus8.out, vec[i].a | vec[i].b);
      @(posedge clk);
      #1;
`ifdef OR_STICKY_EN
      exp_acc = vec[i].acc;
`else
      exp_acc = 8'h00;
`endif
      check("out_q", i, bus8.out_q, vec[i].out_q);
      check("out_valid", i, {7'd0, bus8.out_valid}, {7'd0, vec[i].vld});
      check("any_q", i, {7'd0, bus8.any_q}, {7'd0, vec[i].any});
      check("acc_q", i, bus8.acc_q, exp_acc);
      if (bus8.out_valid) begin
        if (sb_q.size() == 0) begin
          check("sb_spurious", i, 8'h01, 8'h00);
        end else begin
          popped = sb_q.pop_front();
          check("sb_out_q", i, bus8.out_q, popped);
        end
      end
    end

    @(negedge clk);
    bus8.in_valid = 1'b0;
    bus8.acc_clr  = 1'b0;
    check("sb_drain", 0, 8'(sb_q.size()), 8'h00);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/or_gate.md
Name: or_gate

Overview:
- Parameterised bitwise 2-input OR primitive for the gate-level library.
- Provides a purely combinational output `out = a | b` for direct gate use.
- Also provides a registered, valid-qualified copy of the result plus a reduction flag for pipelined users.
- Optionally provides a sticky OR-accumulator.

Parameters:
- WIDTH, 1, bit width of a, b, out, out_q and acc_q (legal range 1..64).

Ports:
- clk  input  1  rising-edge clock for all registered outputs.
- rst  input  1  synchronous active-high reset.
- a  input  WIDTH  operand A.
- b  input  WIDTH  operand B.
- in_valid  input  1  qualifies a/b for the registered path.
- acc_clr  input  1  clears the sticky accumulator (only used with OR_STICKY_EN).
- out  output  WIDTH  combinational a | b.
- out_q  output  WIDTH  registered a | b.
- out_valid  output  1  out_q updated on the last edge.
- any_q  output  1  registered reduction-OR of (a | b).
- acc_q  output  WIDTH  sticky OR-accumulator.

Behaviour:
- Combinational path:
  - out = a | b, bitwise, zero latency.
  - Independent of clk, rst and in_valid; valid with no clock running.
  - Truth table per bit: 00->0, 01->1, 10->1, 11->1.
- Reset:
  - rst sampled high at a rising clk edge sets out_q=0, out_valid=0, any_q=0, acc_q=0.
  - rst has priority over in_valid and acc_clr.
  - Reset does not affect `out`.
- Registered path (1-cycle latency):
  - Edge with in_valid=1: out_q <= a|b, any_q <= |(a|b), out_valid <= 1.
  - Edge with in_valid=0: out_q and any_q hold, out_valid <= 0.
  - out_valid is a one-cycle pulse per accepted input. Back-to-back in_valid yields continuous out_valid.
  - No backpressure; every valid input is accepted.
- Width rules:
  - All vectors are exactly WIDTH bits; no carries or extension.
  - any_q is 1 iff at least one bit of a|b is 1.
- Reset mid-operation: an in_valid asserted in the same cycle as rst is discarded; no out_valid follows.

Optional Feature:
- Macro: OR_STICKY_EN.
- Defined:
  - acc_q accumulates the OR of every accepted input since the last clear.
  - Edge with acc_clr=1 and in_valid=1: acc_q <= a|b (clear then load).
  - Edge with acc_clr=1 and in_valid=0: acc_q <= 0.
  - Edge with acc_clr=0 and in_valid=1: acc_q <= acc_q | a | b.
  - Otherwise acc_q holds. Reset clears it.
- Not defined:
  - acc_q is driven constant 0 and acc_clr is ignored.
  - No accumulator flops are inferred.
  - Port list is identical in both builds.

Test Plan:
- WIDTH=1, no clock, rst low. Apply a,b = 00, 01, 10, 11, 10 ns each -> out = 0, 1, 1, 1 sampled after each 10 ns step.
- WIDTH=8, rst held 2 cycles -> out_q=0x00, out_valid=0, any_q=0, acc_q=0x00. `out` still tracks a|b during reset.
- WIDTH=8, in_valid=1 with a=0xA0, b=0x05 -> next edge out_q=0xA5, any_q=1, out_valid=1. in_valid then dropped -> out_valid=0, out_q holds 0xA5.
- WIDTH=8, in_valid=1, a=b=0x00 -> out_q=0x00, any_q=0, out_valid=1. Then rst=1 with in_valid=1, a=0xFF -> out_q=0x00, out_valid=0.
- OR_STICKY_EN, WIDTH=8, sequence:
  - accept 0x01, 0x10, 0x80 -> acc_q = 0x01, 0x11, 0x91.
  - acc_clr with in_valid and a|b=0x04 -> acc_q=0x04.
  - acc_clr alone -> acc_q=0x00.
- Without OR_STICKY_EN, same sequence -> acc_q stays 0x00 throughout; all other outputs match the earlier cases.
